ex_stage_md: RTL and testbench
==============================

Name: ex_stage_md

Overview:
Next-generation execute stage for the RV32I pipeline, parametrised in data width, adding RV32M multiply/divide.
- Operand forwarding muxes; full funct3 branch resolution (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- Iterative multi-cycle mul/div unit with a stall handshake toward the hazard unit.
- EX/MEM pipeline register with hold and bubble insertion.
- Sits between the ID/EX register and the MEM stage.

Parameters:
XLEN, 32, datapath width (even, >=8)
RA_W, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
hold_M  in  1  MEM stage stall; EX/MEM register and mul/div unit freeze
regWrite_E, memWrite_E, memRead_E, jump_E, branch_E, muxjalr, alu_srcB_E  in  1 each  decoded controls
md_en_E  in  1  instruction in E is RV32M
resultScr_E  in  3  writeback select
alu_ctrl_E  in  4  ALU op (ex_pkg encoding)
funct3_E  in  3  branch type / md op / mem mode
fwdA_sel, fwdB_sel  in  2 each  00 RD, 01 ALURslt_M, 10 result_W
pc_E, pc4_E, imm_E, RD1_E, RD2_E  in  XLEN each  operands
ALURslt_M_fb, result_W  in  XLEN each  forwarding sources
rd_E  in  RA_W  destination
ex_busy  out  1  stall IF/ID/E; inject bubble
PCSrc_E  out  1  redirect
PC_target_E  out  XLEN  branch/jump target
regWrite_M, memWrite_M, memRead_M  out  1 each
resultScr_M, mode_M  out  3 each
ALURslt_M, write_Data_M, imm_M, pc4_M, PC_target_M  out  XLEN each
rd_M  out  RA_W

Behaviour:
- Forwarding: A = mux(fwdA_sel); B_fwd = mux(fwdB_sel); sel 11 behaves as 00. ALU operand B = alu_srcB_E ? imm_E : B_fwd. write_Data = B_fwd.
- Target: PC_target_E = (muxjalr ? A : pc_E) + imm_E, modulo 2^XLEN. For JALR, bit0 is cleared.
- Branch: taken per funct3_E with signed/unsigned compare of A vs B_fwd. Undefined funct3 gives not-taken.
- PCSrc_E = (branch_E & taken) | jump_E. Forced 0 while ex_busy.
- Mul/div FSM (in md_unit): IDLE, RUN, DONE.
  - IDLE & md_en_E & !hold_M: latch |A|, |B|, signs and op; clear count; go to RUN. ex_busy=1 combinationally this cycle.
  - RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle; count increments. After XLEN steps go to DONE. ex_busy=1.
  - DONE: result sign-corrected; ex_busy=0. If !hold_M, EX/MEM loads the result and the FSM returns to IDLE. Otherwise it stays in DONE.
  - Total E occupancy is XLEN+2 cycles; ex_busy is high for XLEN+1 cycles.
- Ops per funct3_E:
  - MUL: low XLEN bits. MULH/MULHSU/MULHU: high XLEN bits, with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- Divide corner cases (RISC-V): divisor 0 gives quotient all-ones and remainder = dividend. Signed overflow (min / -1) gives quotient = min and remainder 0. Both still take the full XLEN+2 cycles.
- EX/MEM register:
  - hold_M: all outputs hold.
  - else ex_busy: load a bubble (regWrite/memWrite/memRead = 0, rd_M = 0; data don't-care but deterministic).
  - else: load E values. ALURslt_M = md result if md_en_E, else the ALU result. mode_M = funct3_E.
- hold_M and ex_busy together: hold wins, and the FSM also freezes, with count unchanged.
- Reset: all EX/MEM outputs 0, FSM to IDLE, count 0, ex_busy 0. Reset mid-RUN aborts the operation with no writeback.

Decomposition:
- Package ex_pkg: alu_ctrl encodings, md op codes (funct3 values), branch funct3 constants, forwarding-select constants, FSM state enum.
- Sub-module md_unit: iterative mul/div with the FSM, counter, sign handling and corner cases. Interface: start, op, a, b, hold, busy, done, result.

Test Plan:
- ADD: RD1=5, RD2=7, fwdB=01 with ALURslt_M_fb=100 -> next cycle ALURslt_M=105, regWrite_M=1, ex_busy never high.
- BLT: A=-1 (0xFFFFFFFF), B=1, pc=0x100, imm=8 -> PCSrc_E=1, PC_target_E=0x108. BLTU with the same operands -> PCSrc_E=0.
- MULH: A=0x80000000, B=2 -> ex_busy high 33 cycles; EX/MEM shows 33 bubbles, then ALURslt_M=0xFFFFFFFF.
- DIV: A=-7, B=2 -> ALURslt_M=-3. REM -> -1. DIVU by 0 -> 0xFFFFFFFF. DIV 0x80000000 by -1 -> 0x80000000. REM of the same -> 0.
- hold_M asserted for 3 cycles in DONE -> outputs frozen, FSM stays in DONE; after release the result is written exactly once.
- rst asserted at RUN count 10 -> next cycle ex_busy=0, all EX/MEM outputs 0; a new MUL 3×4 then yields 12.

Source files
------------

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared encodings and helpers for the RV32IM execute stage
package ex_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [1:0] FWD_RD  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  function automatic logic md_a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/ex_stage_md_if.sv
// rtl/ex_stage_md_if.sv - ID/EX inputs and EX/MEM outputs of the execute stage
interface ex_stage_md_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            hold_M;
  logic            regWrite_E, memWrite_E, memRead_E, jump_E, branch_E, muxjalr, alu_srcB_E;
  logic            md_en_E;
  logic [2:0]      resultScr_E;
  logic [3:0]      alu_ctrl_E;
  logic [2:0]      funct3_E;
  logic [1:0]      fwdA_sel, fwdB_sel;
  logic [XLEN-1:0] pc_E, pc4_E, imm_E, RD1_E, RD2_E;
  logic [XLEN-1:0] ALURslt_M_fb, result_W;
  logic [RA_W-1:0] rd_E;

  logic            ex_busy;
  logic            PCSrc_E;
  logic [XLEN-1:0] PC_target_E;
  logic            regWrite_M, memWrite_M, memRead_M;
  logic [2:0]      resultScr_M, mode_M;
  logic [XLEN-1:0] ALURslt_M, write_Data_M, imm_M, pc4_M, PC_target_M;
  logic [RA_W-1:0] rd_M;

  modport master (
    output hold_M, regWrite_E, memWrite_E, memRead_E, jump_E, branch_E, muxjalr, alu_srcB_E,
           md_en_E, resultScr_E, alu_ctrl_E, funct3_E, fwdA_sel, fwdB_sel,
           pc_E, pc4_E, imm_E, RD1_E, RD2_E, ALURslt_M_fb, result_W, rd_E,
    input  ex_busy, PCSrc_E, PC_target_E, regWrite_M, memWrite_M, memRead_M,
           resultScr_M, mode_M, ALURslt_M, write_Data_M, imm_M, pc4_M, PC_target_M, rd_M
  );

  modport slave (
    input  hold_M, regWrite_E, memWrite_E, memRead_E, jump_E, branch_E, muxjalr, alu_srcB_E,
           md_en_E, resultScr_E, alu_ctrl_E, funct3_E, fwdA_sel, fwdB_sel,
           pc_E, pc4_E, imm_E, RD1_E, RD2_E, ALURslt_M_fb, result_W, rd_E,
    output ex_busy, PCSrc_E, PC_target_E, regWrite_M, memWrite_M, memRead_M,
           resultScr_M, mode_M, ALURslt_M, write_Data_M, imm_M, pc4_M, PC_target_M, rd_M
  );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative RV32M multiply/divide, one bit per cycle
module md_unit
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  md_state_t         state, state_nx;
  logic [CW-1:0]     count;
  logic [XLEN-1:0]   hi, lo, mb;
  logic [2:0]        op_q;
  logic              neg_a, neg_b, div_zero;

  logic              sa, sb, launch, step, div_ge;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     mul_sum, div_sh;
  logic [2*XLEN-1:0] prod_neg;

  always_comb begin
    sa      = md_a_signed(op) & a[XLEN-1];
    sb      = md_b_signed(op) & b[XLEN-1];
    abs_a   = sa ? -a : a;
    abs_b   = sb ? -b : b;
    launch  = (state == MD_IDLE) && start && !hold;
    step    = (state == MD_RUN) && !hold;
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mb} : '0);
    div_sh  = {hi, lo[XLEN-1]};
    div_ge  = (div_sh >= {1'b0, mb});
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nx;
  end

  // hi/lo hold the product for mul, remainder/quotient for div; magnitudes only
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      mb       <= '0;
      op_q     <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
    end else if (launch) begin
      count    <= '0;
      hi       <= '0;
      lo       <= abs_a;
      mb       <= abs_b;
      op_q     <= op;
      neg_a    <= sa;
      neg_b    <= sb;
      div_zero <= (b == '0);
    end else if (step) begin
      count <= count + CW'(1);
      if (op_q[2]) begin
        hi <= div_ge ? div_sh[XLEN-1:0] - mb : div_sh[XLEN-1:0];
        lo <= {lo[XLEN-2:0], div_ge};
      end else begin
        hi <= mul_sum[XLEN:1];
        lo <= {mul_sum[0], lo[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      MD_IDLE: if (launch) state_nx = MD_RUN;
      MD_RUN:  if (step && count == LAST) state_nx = MD_DONE;
      MD_DONE: if (!hold) state_nx = MD_IDLE;
      default: state_nx = MD_IDLE;
    endcase
  end

  always_comb begin
    busy     = launch || (state == MD_RUN);
    done     = (state == MD_DONE);
    prod_neg = -{hi, lo};
    result   = lo;
    case (op_q)
      MD_MULH, MD_MULHSU, MD_MULHU: result = (neg_a ^ neg_b) ? prod_neg[2*XLEN-1:XLEN] : hi;
      // min / -1 falls out of the magnitude path; only divide-by-zero needs patching
      MD_DIV, MD_DIVU:              result = div_zero ? '1 : ((neg_a ^ neg_b) ? -lo : lo);
      MD_REM, MD_REMU:              result = neg_a ? -hi : hi;
      default:                      result = lo;
    endcase
  end

endmodule

// File: rtl/ex_stage_md.sv
// rtl/ex_stage_md.sv - RV32IM execute stage with forwarding, branch resolve and EX/MEM register
module ex_stage_md
  import ex_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input logic         clk,
  input logic         rst,
  ex_stage_md_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [RA_W-1:0] RD_NONE = '0;

  logic [XLEN-1:0] a_op, b_fwd, b_op, alu_y, tgt_sum, md_result, res_sel;
  logic            taken, md_busy, md_done;
  logic [SHW-1:0]  shamt;

  always_comb begin
    case (bus.fwdA_sel)
      FWD_MEM: a_op = bus.ALURslt_M_fb;
      FWD_WB:  a_op = bus.result_W;
      default: a_op = bus.RD1_E;
    endcase
    case (bus.fwdB_sel)
      FWD_MEM: b_fwd = bus.ALURslt_M_fb;
      FWD_WB:  b_fwd = bus.result_W;
      default: b_fwd = bus.RD2_E;
    endcase
    b_op  = bus.alu_srcB_E ? bus.imm_E : b_fwd;
    shamt = b_op[SHW-1:0];
  end

  always_comb begin
    case (bus.alu_ctrl_E)
      ALU_ADD:   alu_y = a_op + b_op;
      ALU_SUB:   alu_y = a_op - b_op;
      ALU_AND:   alu_y = a_op & b_op;
      ALU_OR:    alu_y = a_op | b_op;
      ALU_XOR:   alu_y = a_op ^ b_op;
      ALU_SLT:   alu_y = {{(XLEN-1){1'b0}}, ($signed(a_op) < $signed(b_op))};
      ALU_SLTU:  alu_y = {{(XLEN-1){1'b0}}, (a_op < b_op)};
      ALU_SLL:   alu_y = a_op << shamt;
      ALU_SRL:   alu_y = a_op >> shamt;
      ALU_SRA:   alu_y = $signed(a_op) >>> shamt;
      ALU_PASSB: alu_y = b_op;
      default:   alu_y = '0;
    endcase
  end

  // branches compare against the forwarded rs2, never the immediate
  always_comb begin
    case (bus.funct3_E)
      BR_BEQ:  taken = (a_op == b_fwd);
      BR_BNE:  taken = (a_op != b_fwd);
      BR_BLT:  taken = ($signed(a_op) < $signed(b_fwd));
      BR_BGE:  taken = ($signed(a_op) >= $signed(b_fwd));
      BR_BLTU: taken = (a_op < b_fwd);
      BR_BGEU: taken = (a_op >= b_fwd);
      default: taken = 1'b0;
    endcase
    tgt_sum = (bus.muxjalr ? a_op : bus.pc_E) + bus.imm_E;
  end

  assign bus.PC_target_E = bus.muxjalr ? {tgt_sum[XLEN-1:1], 1'b0} : tgt_sum;
  assign bus.PCSrc_E     = !md_busy && ((bus.branch_E && taken) || bus.jump_E);
  assign bus.ex_busy     = md_busy;
  assign res_sel         = (bus.md_en_E && md_done) ? md_result : alu_y;

  md_unit #(
    .XLEN (XLEN)
  ) u_md (
    .clk    (clk),
    .rst    (rst),
    .hold   (bus.hold_M),
    .start  (bus.md_en_E),
    .op     (bus.funct3_E),
    .a      (a_op),
    .b      (b_fwd),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // bubbles are loaded as all-zero so the MEM stage sees a clean NOP
  always_ff @(posedge clk) begin
    if (rst || (!bus.hold_M && md_busy)) begin
      bus.regWrite_M   <= 1'b0;
      bus.memWrite_M   <= 1'b0;
      bus.memRead_M    <= 1'b0;
      bus.resultScr_M  <= '0;
      bus.mode_M       <= '0;
      bus.ALURslt_M    <= '0;
      bus.write_Data_M <= '0;
      bus.imm_M        <= '0;
      bus.pc4_M        <= '0;
      bus.PC_target_M  <= '0;
      bus.rd_M         <= RD_NONE;
    end else if (!bus.hold_M) begin
      bus.regWrite_M   <= bus.regWrite_E;
      bus.memWrite_M   <= bus.memWrite_E;
      bus.memRead_M    <= bus.memRead_E;
      bus.resultScr_M  <= bus.resultScr_E;
      bus.mode_M       <= bus.funct3_E;
      bus.ALURslt_M    <= res_sel;
      bus.write_Data_M <= b_fwd;
      bus.imm_M        <= bus.imm_E;
      bus.pc4_M        <= bus.pc4_E;
      bus.PC_target_M  <= bus.PC_target_E;
      bus.rd_M         <= bus.rd_E;
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// tb/tb_ex_stage_md.sv - randomized self-checking bench for ex_stage_md
module tb_ex_stage_md;
  import ex_pkg::*;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_stage_md_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

  ex_stage_md #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0]  ctl;
    logic [1:0]  fa, fb;
    logic [31:0] rd1, rd2, mfb, wb, imm, pc;
    logic        src_b, br, jmp, jalr, rw, mw, mr;
    logic [2:0]  f3, rs;
    logic [4:0]  rd;
  } alu_tc_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_XOR:   return a ^ b;
      ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:   return a << b[4:0];
      ALU_SRL:   return a >> b[4:0];
      ALU_SRA:   return 32'($signed(a) >>> b[4:0]);
      ALU_PASSB: return b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int ia, ib;
    logic ovf;
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'b001: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      3'b010: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic set_nop();
    bus.hold_M = 0; bus.regWrite_E = 0; bus.memWrite_E = 0; bus.memRead_E = 0;
    bus.jump_E = 0; bus.branch_E = 0; bus.muxjalr = 0; bus.alu_srcB_E = 0; bus.md_en_E = 0;
    bus.resultScr_E = 0; bus.alu_ctrl_E = 0; bus.funct3_E = 0; bus.fwdA_sel = 0; bus.fwdB_sel = 0;
    bus.pc_E = 0; bus.pc4_E = 0; bus.imm_E = 0; bus.RD1_E = 0; bus.RD2_E = 0;
    bus.ALURslt_M_fb = 0; bus.result_W = 0; bus.rd_E = 0;
  endtask

  function automatic alu_tc_t rand_tc();
    alu_tc_t t;
    t.ctl = 4'($urandom_range(0, 10));
    t.fa = 2'($urandom); t.fb = 2'($urandom);
    t.rd1 = $urandom; t.rd2 = $urandom; t.mfb = $urandom; t.wb = $urandom;
    t.imm = $urandom; t.pc = $urandom;
    t.src_b = 1'($urandom); t.br = 1'($urandom); t.jmp = ($urandom_range(0, 3) == 0);
    t.jalr = 1'($urandom); t.rw = 1'($urandom); t.mw = 1'($urandom); t.mr = 1'($urandom);
    t.f3 = 3'($urandom); t.rs = 3'($urandom); t.rd = 5'($urandom);
    return t;
  endfunction

  task automatic run_alu(input alu_tc_t t, output logic [31:0] res);
    logic [31:0] ea, ebf, eb, tgt;
    logic pcs;
    bus.hold_M = 0; bus.md_en_E = 0;
    bus.alu_ctrl_E = t.ctl; bus.fwdA_sel = t.fa; bus.fwdB_sel = t.fb;
    bus.RD1_E = t.rd1; bus.RD2_E = t.rd2; bus.ALURslt_M_fb = t.mfb; bus.result_W = t.wb;
    bus.imm_E = t.imm; bus.pc_E = t.pc; bus.pc4_E = t.pc + 4;
    bus.alu_srcB_E = t.src_b; bus.branch_E = t.br; bus.jump_E = t.jmp; bus.muxjalr = t.jalr;
    bus.regWrite_E = t.rw; bus.memWrite_E = t.mw; bus.memRead_E = t.mr;
    bus.funct3_E = t.f3; bus.resultScr_E = t.rs; bus.rd_E = t.rd;
    ea  = (t.fa == 2'b01) ? t.mfb : (t.fa == 2'b10) ? t.wb : t.rd1;
    ebf = (t.fb == 2'b01) ? t.mfb : (t.fb == 2'b10) ? t.wb : t.rd2;
    eb  = t.src_b ? t.imm : ebf;
    tgt = (t.jalr ? ea : t.pc) + t.imm;
    if (t.jalr) tgt[0] = 1'b0;
    pcs = (t.br && ref_taken(t.f3, ea, ebf)) || t.jmp;
    res = ref_alu(t.ctl, ea, eb);
    #1;
    check("pcsrc", bus.PCSrc_E, pcs);
    check("target", bus.PC_target_E, tgt);
    check("busy_alu", bus.ex_busy, 0);
    @(posedge clk); @(negedge clk);
    check("alu_res", bus.ALURslt_M, res);
    check("wdata", bus.write_Data_M, ebf);
    check("ctrl_m", {bus.regWrite_M, bus.memWrite_M, bus.memRead_M, bus.resultScr_M, bus.mode_M, bus.rd_M},
          {t.rw, t.mw, t.mr, t.rs, t.f3, t.rd});
    check("imm_pc4_m", {bus.imm_M, bus.pc4_M}, {t.imm, t.pc + 32'd4});
    check("tgt_m", bus.PC_target_M, tgt);
  endtask

  task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold_run, input int hold_done);
    logic [4:0] rd;
    int n, bad;
    rd = 5'($urandom_range(1, 31));
    set_nop();
    bus.md_en_E = 1; bus.funct3_E = op; bus.RD1_E = a; bus.RD2_E = b;
    bus.regWrite_E = 1; bus.rd_E = rd; bus.jump_E = 1; bus.alu_ctrl_E = 4'($urandom_range(0, 10));
    #1;
    check("md_pcsrc_gated", bus.PCSrc_E, 0);
    n = 0; bad = 0;
    while (bus.ex_busy === 1'b1 && n < 200) begin
      n++;
      bus.hold_M = (n > 5 && n <= 5 + hold_run);
      @(posedge clk); @(negedge clk);
      if (bus.regWrite_M !== 1'b0 || bus.rd_M !== 5'd0) bad++;
    end
    check("md_busy_cycles", n, 33 + hold_run);
    check("md_bubbles", bad, 0);
    bad = 0;
    bus.hold_M = 1;
    for (int i = 0; i < hold_done; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus.ex_busy !== 1'b0 || bus.regWrite_M !== 1'b0 || bus.ALURslt_M !== 32'd0) bad++;
    end
    check("md_done_hold", bad, 0);
    bus.hold_M = 0;
    @(posedge clk); @(negedge clk);
    check("md_result", bus.ALURslt_M, ref_md(op, a, b));
    check("md_wb", {bus.regWrite_M, bus.rd_M}, {1'b1, rd});
    set_nop();
    @(posedge clk); @(negedge clk);
    check("md_once", bus.regWrite_M, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    alu_tc_t t;
    logic [31:0] r, a, b;
    logic [2:0] op;

    set_nop();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.ex_busy, 0);
    check("rst_ctrl", {bus.regWrite_M, bus.memWrite_M, bus.memRead_M, bus.resultScr_M, bus.mode_M, bus.rd_M}, 0);
    check("rst_data", {bus.ALURslt_M, bus.write_Data_M}, 0);
    check("rst_misc", {bus.imm_M, bus.pc4_M}, 0);
    check("rst_tgt", bus.PC_target_M, 0);
    rst = 0;

    t = rand_tc();
    t.ctl = ALU_ADD; t.fa = 2'b00; t.fb = 2'b01; t.rd1 = 5; t.rd2 = 7; t.mfb = 100; t.src_b = 0;
    run_alu(t, r);
    check("add_fwd", bus.ALURslt_M, 105);

    t.br = 1; t.jmp = 0; t.jalr = 0; t.fb = 2'b00; t.rd1 = 32'hFFFF_FFFF; t.rd2 = 1;
    t.pc = 32'h100; t.imm = 8; t.f3 = BR_BLT;
    run_alu(t, r);
    check("blt_tgt_m", bus.PC_target_M, 32'h108);
    t.f3 = BR_BLTU;
    run_alu(t, r);

    for (int i = 0; i < 30; i++) begin
      t = rand_tc();
      run_alu(t, r);
    end

    t = rand_tc();
    run_alu(t, r);
    bus.hold_M = 1; bus.alu_ctrl_E = ~t.ctl; bus.RD1_E = ~t.rd1; bus.regWrite_E = ~t.rw; bus.rd_E = ~t.rd;
    @(posedge clk); @(negedge clk);
    check("hold_res", bus.ALURslt_M, r);
    check("hold_ctrl", {bus.regWrite_M, bus.rd_M}, {t.rw, t.rd});
    set_nop();

    do_md(MD_MULH, 32'h8000_0000, 32'd2, 0, 0);
    do_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
    do_md(MD_REM, 32'hFFFF_FFF9, 32'd2, 0, 0);
    do_md(MD_DIVU, 32'h1234_5678, 32'd0, 0, 0);
    do_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_md(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_md(MD_DIV, 32'hFFFF_FFF9, 32'd0, 0, 0);
    do_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 3);
    do_md(MD_MUL, 32'hFFFF_FFFD, 32'd7, 2, 1);

    for (int i = 0; i < 14; i++) begin
      op = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 9);
        default: ;
      endcase
      do_md(op, a, b, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    set_nop();
    bus.md_en_E = 1; bus.funct3_E = MD_MUL; bus.RD1_E = $urandom; bus.RD2_E = $urandom;
    bus.regWrite_E = 1; bus.rd_E = 5'd9;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1;
    set_nop();
    @(posedge clk); @(negedge clk);
    check("rst_run_busy", bus.ex_busy, 0);
    check("rst_run_ctrl", {bus.regWrite_M, bus.memWrite_M, bus.memRead_M, bus.rd_M}, 0);
    check("rst_run_res", bus.ALURslt_M, 0);
    rst = 0;
    do_md(MD_MUL, 32'd3, 32'd4, 0, 0);
    check("mul_after_rst", bus.rd_M, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
